fast_shutter_ctrl_mc: RTL and testbench

Multi-channel, parametrised fast-shutter driver. Per channel it latches a target position from a hardware or software request, waits a settle delay, then drives a fixed-width actuation pulse. It then debounces the two-wire position feedback and verifies that the shutter reached the target within a timeout. It reports actuation time, done and sticky fault per channel, and sits between the timing/register logic and the shutter driver board pins.

---
 rtl/fast_shutter_ctrl_mc.sv | 175 +++++++++++++++++
 tb/tb_fast_shutter_ctrl_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_shutter_ctrl_mc.sv
// Multi-channel fast-shutter driver: request edge -> settle -> actuation pulse ->
// verify debounced two-wire feedback against target, with sticky timeout fault.
module fast_shutter_ctrl_mc #(
    parameter int unsigned CH_NUM         = 2,
    parameter int unsigned PRE_CYCLES     = 262144,
    parameter int unsigned PULSE_CYCLES   = 262144,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned TIME_W         = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [CH_NUM-1:0]          fast_shutter_en_i,
    input  logic [CH_NUM-1:0]          fast_shutter_set_i,
    input  logic [CH_NUM-1:0]          soft_fast_shutter_en_i,
    input  logic [CH_NUM-1:0]          soft_fast_shutter_set_i,
    input  logic [CH_NUM-1:0]          fault_clr_i,
    input  logic [CH_NUM-1:0]          fast_back_in1_i,
    input  logic [CH_NUM-1:0]          fast_back_in2_i,
    output logic [CH_NUM-1:0]          fast_shutter_out1_o,
    output logic [CH_NUM-1:0]          fast_shutter_out2_o,
    output logic [CH_NUM-1:0]          fast_shutter_state_o,
    output logic [CH_NUM-1:0]          fast_shutter_busy_o,
    output logic [CH_NUM-1:0]          fast_shutter_done_o,
    output logic [CH_NUM-1:0]          fast_shutter_fault_o,
    output logic [CH_NUM*TIME_W-1:0]   fast_shutter_act_time_o
);

    localparam int unsigned MAX_A = (PRE_CYCLES > PULSE_CYCLES) ? PRE_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_C + 1);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEB_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DRIVE, S_VERIFY} state_e;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        state_e             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic               req_d0_q, req_d1_q, accept;
        logic               tgt_q, tgt_d;
        logic [1:0]         sync1_q, sync2_q, pat_q;
        logic [DEB_W-1:0]   deb_q, deb_d;
        logic               pos_q, pos_d;
        logic               out1_q, done_q, done_d, fault_q, fault_d, fault_set;
        logic [TIME_W-1:0]  act_q, act_d;

        assign accept = req_d0_q & ~req_d1_q;

        // Feedback pattern {in1,in2}: 10 -> open, 01 -> closed, 00/11 invalid.
        always_comb begin
            deb_d = '0;
            pos_d = pos_q;
            if (sync2_q[1] ^ sync2_q[0]) begin
                if (sync2_q == pat_q) begin
                    deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_W'(1);
                end else begin
                    deb_d = DEB_W'(1);
                end
                if (deb_d == DEB_MAX) begin
                    pos_d = sync2_q[1];
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            done_d    = 1'b0;
            fault_set = 1'b0;
            tgt_d     = tgt_q;
            act_d     = act_q;

            case (state_q)
                S_PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = S_VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    if (pos_q == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        fault_set = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            // A new request edge aborts any sequence in flight, suppressing its done/fault.
            if (accept) begin
                state_d   = S_PRE;
                cnt_d     = '0;
                done_d    = 1'b0;
                fault_set = 1'b0;
            end

            fault_d = fault_set ? 1'b1 : (fault_clr_i[g] ? 1'b0 : fault_q);

            if (fast_shutter_en_i[g]) begin
                tgt_d = fast_shutter_set_i[g];
            end else if (soft_fast_shutter_en_i[g]) begin
                tgt_d = soft_fast_shutter_set_i[g];
            end

            if (accept) begin
                act_d = '0;
            end else if ((state_q != S_IDLE) && (pos_q != tgt_q) && (act_q != '1)) begin
                act_d = act_q + TIME_W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                req_d0_q <= 1'b0;
                req_d1_q <= 1'b0;
                tgt_q    <= 1'b0;
                sync1_q  <= '0;
                sync2_q  <= '0;
                pat_q    <= '0;
                deb_q    <= '0;
                pos_q    <= 1'b0;
                out1_q   <= 1'b0;
                done_q   <= 1'b0;
                fault_q  <= 1'b0;
                act_q    <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                req_d0_q <= fast_shutter_en_i[g] | soft_fast_shutter_en_i[g];
                req_d1_q <= req_d0_q;
                tgt_q    <= tgt_d;
                sync1_q  <= {fast_back_in1_i[g], fast_back_in2_i[g]};
                sync2_q  <= sync1_q;
                pat_q    <= sync2_q;
                deb_q    <= deb_d;
                pos_q    <= pos_d;
                out1_q   <= (state_d == S_DRIVE);
                done_q   <= done_d;
                fault_q  <= fault_d;
                act_q    <= act_d;
            end
        end

        assign fast_shutter_out1_o[g]                   = out1_q;
        assign fast_shutter_out2_o[g]                   = tgt_q;
        assign fast_shutter_state_o[g]                  = pos_q;
        assign fast_shutter_busy_o[g]                   = (state_q != S_IDLE);
        assign fast_shutter_done_o[g]                   = done_q;
        assign fast_shutter_fault_o[g]                  = fault_q;
        assign fast_shutter_act_time_o[g*TIME_W +: TIME_W] = act_q;
    end

endmodule

// File: tb/tb_fast_shutter_ctrl_mc.sv
// Bench for fast_shutter_ctrl_mc: vector table, corner-case sequences and random
// stimulus, all checked every cycle against an elapsed-time reference model.
module tb_fast_shutter_ctrl_mc;

    localparam int CH    = 2;
    localparam int PRE   = 4;
    localparam int PULSE = 3;
    localparam int TO    = 14;
    localparam int DEB   = 4;
    localparam int TW    = 16;
    localparam longint ACT_MAX = (longint'(1) << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0] en_r = '0, set_r = '0, sen_r = '0, sset_r = '0, clr_r = '0;
    logic [CH-1:0] fb1_r = '0, fb2_r = '0;
    logic [CH-1:0] out1_o, out2_o, state_o, busy_o, done_o, fault_o;
    logic [CH*TW-1:0] act_o;

    always #5 clk = ~clk;

    fast_shutter_ctrl_mc #(
        .CH_NUM(CH), .PRE_CYCLES(PRE), .PULSE_CYCLES(PULSE),
        .TIMEOUT_CYCLES(TO), .DEB_CYCLES(DEB), .TIME_W(TW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .fast_shutter_en_i(en_r), .fast_shutter_set_i(set_r),
        .soft_fast_shutter_en_i(sen_r), .soft_fast_shutter_set_i(sset_r),
        .fault_clr_i(clr_r), .fast_back_in1_i(fb1_r), .fast_back_in2_i(fb2_r),
        .fast_shutter_out1_o(out1_o), .fast_shutter_out2_o(out2_o),
        .fast_shutter_state_o(state_o), .fast_shutter_busy_o(busy_o),
        .fast_shutter_done_o(done_o), .fast_shutter_fault_o(fault_o),
        .fast_shutter_act_time_o(act_o)
    );

    int n_pass = 0;
    int n_total = 0;
    int done_cnt [CH];

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference model: a sequence is an elapsed-time counter t since acceptance;
    // phase follows from t, debounced position from a raw-sample history.
    bit          m_rq1 [CH], m_rq2 [CH], m_tgt [CH], m_state [CH];
    bit          m_active [CH], m_done [CH], m_fault [CH], m_out1 [CH];
    int          m_t [CH];
    longint      m_act [CH];
    logic [1:0]  m_hist [CH][DEB+2];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_rq1[c] = 0; m_rq2[c] = 0; m_tgt[c] = 0; m_state[c] = 0;
            m_active[c] = 0; m_done[c] = 0; m_fault[c] = 0; m_out1[c] = 0;
            m_t[c] = 0; m_act[c] = 0;
            for (int j = 0; j < DEB + 2; j++) m_hist[c][j] = 2'b00;
        end
    endtask

    task automatic model_step();
        bit acc, os, ot, oa, fset, ok;
        int ott;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            os = m_state[c]; ot = m_tgt[c]; oa = m_active[c]; ott = m_t[c];
            acc = m_rq1[c] && !m_rq2[c];
            fset = 0;
            m_done[c] = 0;
            if (acc) m_act[c] = 0;
            else if (oa && os != ot && m_act[c] < ACT_MAX) m_act[c]++;
            if (acc) begin
                m_active[c] = 1; m_t[c] = 0;
            end else if (oa) begin
                if (ott >= PRE + PULSE && os == ot) begin
                    m_done[c] = 1; m_active[c] = 0;
                end else if (ott >= PRE + PULSE && ott - (PRE + PULSE) == TO - 1) begin
                    fset = 1; m_active[c] = 0;
                end else begin
                    m_t[c] = ott + 1;
                end
            end
            if (fset) m_fault[c] = 1;
            else if (clr_r[c]) m_fault[c] = 0;
            m_out1[c] = m_active[c] && m_t[c] >= PRE && m_t[c] < PRE + PULSE;
            if (en_r[c]) m_tgt[c] = set_r[c];
            else if (sen_r[c]) m_tgt[c] = sset_r[c];
            m_rq2[c] = m_rq1[c];
            m_rq1[c] = en_r[c] | sen_r[c];
            for (int j = DEB + 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = {fb1_r[c], fb2_r[c]};
            ok = (m_hist[c][2][1] ^ m_hist[c][2][0]);
            for (int j = 3; j < DEB + 2; j++) if (m_hist[c][j] != m_hist[c][2]) ok = 0;
            if (ok) m_state[c] = m_hist[c][2][1];
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("ch%0d out1", c),  out1_o[c],  m_out1[c]);
            chk($sformatf("ch%0d out2", c),  out2_o[c],  m_tgt[c]);
            chk($sformatf("ch%0d state", c), state_o[c], m_state[c]);
            chk($sformatf("ch%0d busy", c),  busy_o[c],  m_active[c]);
            chk($sformatf("ch%0d done", c),  done_o[c],  m_done[c]);
            chk($sformatf("ch%0d fault", c), fault_o[c], m_fault[c]);
            chk($sformatf("ch%0d act", c),   act_o[c*TW +: TW], m_act[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        for (int c = 0; c < CH; c++) done_cnt[c] += int'(done_o[c]);
    endtask

    task automatic wait_out1(input int c, input bit val);
        int n;
        n = 0;
        while (out1_o[c] !== val && n < 60) begin
            tick();
            n++;
        end
        if (out1_o[c] !== val) chk($sformatf("ch%0d wait out1=%0d", c, val), 0, 1);
    endtask

    task automatic set_fb(input int c, input logic [1:0] p);
        fb1_r[c] = p[1];
        fb2_r[c] = p[0];
    endtask

    typedef struct {
        int ch; bit en; bit set; bit sen; bit sset;
        logic [1:0] fb; int d;
        bit exp_out2; int exp_done; bit exp_fault; int exp_act;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n, d0;
        for (int c = 0; c < CH; c++) done_cnt[c] = 0;
        // act = PRE+PULSE+d+2+DEB when feedback lands d cycles after the pulse;
        // a timeout counts every busy cycle: PRE+PULSE+TO = 21.
        tbl[0] = '{0, 1, 1, 0, 0, 2'b10, 5, 1, 1, 0, 18};
        tbl[1] = '{0, 1, 0, 0, 0, 2'b01, 7, 0, 1, 0, 20};
        tbl[2] = '{0, 1, 1, 0, 0, 2'b11, 0, 1, 0, 1, 21};
        tbl[3] = '{1, 0, 0, 1, 0, 2'b01, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 1, 0, 1, 1, 2'b01, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 1, 1, 0, 0, 2'b10, 8, 1, 0, 1, 21};

        model_reset();
        repeat (3) tick();
        chk("reset act vector", act_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            int c;
            c = tbl[i].ch;
            d0 = done_cnt[c];
            en_r[c] = tbl[i].en; set_r[c] = tbl[i].set;
            sen_r[c] = tbl[i].sen; sset_r[c] = tbl[i].sset;
            tick();
            en_r[c] = 0; sen_r[c] = 0;
            wait_out1(c, 1'b1);
            wait_out1(c, 1'b0);
            repeat (tbl[i].d) tick();
            set_fb(c, tbl[i].fb);
            n = 0;
            while (busy_o[c] && n < 60) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d completes", i), busy_o[c], 0);
            chk($sformatf("vec%0d out2", i), out2_o[c], tbl[i].exp_out2);
            chk($sformatf("vec%0d done count", i), done_cnt[c] - d0, tbl[i].exp_done);
            chk($sformatf("vec%0d fault", i), fault_o[c], tbl[i].exp_fault);
            chk($sformatf("vec%0d act", i), act_o[c*TW +: TW], tbl[i].exp_act);
            repeat (2) tick();
        end

        // Asynchronous reset in the middle of the drive pulse.
        set_fb(0, 2'b11);
        en_r = '1; set_r = '0;
        tick();
        en_r = '0;
        wait_out1(0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out1", out1_o, 0);
        chk("async rst busy", busy_o, 0);
        chk("async rst fault", fault_o, 0);
        chk("async rst act", act_o, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("idle after reset", busy_o, 0);

        // Timeout latency, clear, then set-beats-clear in the same cycle.
        en_r[0] = 1; set_r[0] = 1;
        tick();
        en_r[0] = 0;
        wait_out1(0, 1'b1);
        wait_out1(0, 1'b0);
        n = 0;
        while (!fault_o[0] && n < 40) begin
            tick();
            n++;
        end
        chk("timeout latency", n, TO);
        chk("busy drops on timeout", busy_o[0], 0);
        clr_r[0] = 1;
        tick();
        clr_r[0] = 0;
        chk("fault cleared", fault_o[0], 0);
        en_r[0] = 1;
        tick();
        en_r[0] = 0;
        wait_out1(0, 1'b1);
        wait_out1(0, 1'b0);
        repeat (TO - 1) tick();
        clr_r[0] = 1;
        tick();
        clr_r[0] = 0;
        chk("set beats clear", fault_o[0], 1);
        tick();
        chk("fault sticky", fault_o[0], 1);

        // Restart during DRIVE with the opposite target.
        d0 = done_cnt[1];
        en_r[1] = 1; set_r[1] = 1;
        tick();
        en_r[1] = 0;
        wait_out1(1, 1'b1);
        en_r[1] = 1; set_r[1] = 0;
        tick();
        en_r[1] = 0;
        chk("restart out1 still high", out1_o[1], 1);
        tick();
        chk("restart out1 forced low", out1_o[1], 0);
        chk("restart busy", busy_o[1], 1);
        chk("restart act cleared", act_o[TW +: TW], 0);
        n = 0;
        while (busy_o[1] && n < 60) begin
            tick();
            n++;
        end
        chk("restart single done", done_cnt[1] - d0, 1);
        chk("restart out2", out2_o[1], 0);

        // Debounce glitch on ch0 while ch1 sees a clean pattern.
        set_fb(0, 2'b10); set_fb(1, 2'b10);
        repeat (3) tick();
        set_fb(0, 2'b11);
        repeat (6) tick();
        chk("glitch ch0 holds", state_o[0], 0);
        chk("clean ch1 updates", state_o[1], 1);
        set_fb(0, 2'b10);
        repeat (4) tick();
        set_fb(0, 2'b11);
        tick();
        chk("deb not early", state_o[0], 0);
        tick();
        chk("deb updates", state_o[0], 1);
        chk("ch1 unaffected", state_o[1], 1);

        // Random traffic on both channels.
        for (int k = 0; k < 500; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 24) == 0) en_r[c] = ~en_r[c];
                if ($urandom_range(0, 29) == 0) sen_r[c] = ~sen_r[c];
                set_r[c]  = 1'($urandom_range(0, 1));
                sset_r[c] = 1'($urandom_range(0, 1));
                clr_r[c]  = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 7) == 0) set_fb(c, 2'($urandom_range(0, 3)));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
